// File: rtl/dbuf2ddr_pkg.sv
// Shared sizing, helper width function and state type for the PE-buffer to DDR drain path.
// The DBUF2DDR_RELU_EN option itself is applied in dbuf2ddr.sv.
package GLOBAL_PARAM;
  localparam int DATA_W     = 16;
  localparam int BATCH      = 2;
  localparam int DDR_W      = 4 * BATCH * DATA_W;
  localparam int PE_NUM_DEF = 32;

  // Bits needed to index n items (at least 1).
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int GRP_W = bw(PE_NUM_DEF / 4);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dbuf2ddr_state_e;
endpackage

// File: rtl/dbuf2ddr_if.sv
// Buffer read port plus DDR write stream between dbuf2ddr (master) and its surroundings (slave).
interface dbuf2ddr_if
  import GLOBAL_PARAM::*;
#(
  parameter int ADDR_W = 8,
  parameter int PE_NUM = PE_NUM_DEF
) ();
  logic [ADDR_W-1:0]              dbuf_rd_addr;
  logic [PE_NUM-1:0]              dbuf_rd_en;
  logic [PE_NUM*BATCH*DATA_W-1:0] dbuf_rd_data;
  logic [DDR_W-1:0]               ddr_data;
  logic                           ddr_valid;
  logic                           ddr_ready;

  modport master (
    output dbuf_rd_addr, dbuf_rd_en, ddr_data, ddr_valid,
    input  dbuf_rd_data, ddr_ready
  );

  modport slave (
    input  dbuf_rd_addr, dbuf_rd_en, ddr_data, ddr_valid,
    output dbuf_rd_data, ddr_ready
  );
endinterface

// File: rtl/dbuf2ddr_sync_fifo.sv
// Small first-word-fall-through FIFO; DEPTH must be a power of two (pointers wrap naturally).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/dbuf2ddr.sv
// Sweeps conf_base..conf_base+conf_len over every active 4-PE group and streams one packed beat per read.
// Define DBUF2DDR_RELU_EN to clamp negative DATA_W elements to zero on the FIFO push path.
module dbuf2ddr
  import GLOBAL_PARAM::*;
#(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = bw(BUF_DEPTH),
  parameter int PE_NUM     = PE_NUM_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] conf_base,
  input  logic [ADDR_W-1:0] conf_len,
  input  logic [PE_NUM-1:0] conf_mask,
  dbuf2ddr_if.master        bus
);
  localparam int G  = PE_NUM / 4;
  localparam int GW = bw(G);
  localparam int UW = BATCH * DATA_W;
  localparam int CW = ((FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH)) + 1;

  dbuf2ddr_state_e   r_state, w_state_next;
  logic [PE_NUM-1:0] r_mask, w_sel_mask;
  logic [ADDR_W-1:0] r_addr, r_end, w_addr_next;
  logic [GW-1:0]     r_grp, r_dgrp, w_grp_next, w_next_grp, w_first, w_conf_first;
  logic [3:0]        r_dmask, w_unit_mask;
  logic              r_inflight, w_has_next, w_issue, w_credit;
  logic [G-1:0]      w_act, w_conf_act;
  logic [DDR_W-1:0]  w_grp_data, w_push_data, w_head;
  logic [CW-1:0]     w_count;
  logic              w_empty, w_full, w_pop;

  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ADDR_W+1)'(BUF_DEPTH)) s = s - (ADDR_W+1)'(BUF_DEPTH);
    return s[ADDR_W-1:0];
  endfunction

  function automatic logic [GW-1:0] first_of(input logic [G-1:0] act);
    logic [GW-1:0] f = '0;
    for (int g = G - 1; g >= 0; g--)
      if (act[g]) f = GW'(g);
    return f;
  endfunction

  function automatic logic [UW-1:0] unit_post(input logic [UW-1:0] u);
    logic [UW-1:0] r = u;
`ifdef DBUF2DDR_RELU_EN
    for (int e = 0; e < BATCH; e++)
      if (u[e*DATA_W + DATA_W - 1]) r[e*DATA_W +: DATA_W] = '0;
`endif
    return r;
  endfunction

  for (genvar gi = 0; gi < G; gi++) begin : g_grp
    assign w_act[gi]             = |r_mask[gi*4 +: 4];
    assign w_conf_act[gi]        = |conf_mask[gi*4 +: 4];
    assign w_sel_mask[gi*4 +: 4] = (r_grp == GW'(gi)) ? r_mask[gi*4 +: 4] : 4'b0;
  end

  assign w_first      = first_of(w_act);
  assign w_conf_first = first_of(w_conf_act);

  // Lowest active group above the current one; none means wrap to the next address.
  always_comb begin
    w_has_next  = 1'b0;
    w_next_grp  = '0;
    w_unit_mask = '0;
    for (int g = G - 1; g >= 0; g--) begin
      if (w_act[g] && (GW'(g) > r_grp)) begin
        w_has_next = 1'b1;
        w_next_grp = GW'(g);
      end
      w_unit_mask = w_unit_mask | w_sel_mask[g*4 +: 4];
    end
  end

  // Inflight read counts against FIFO space so a returning beat always has a slot.
  assign w_credit = !w_full && ((int'(w_count) + int'(r_inflight)) < FIFO_DEPTH);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_grp_next   = r_grp;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_addr_next  = conf_base;
          w_grp_next   = w_conf_first;
          w_state_next = (|conf_mask) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_has_next) begin
            w_grp_next = w_next_grp;
          end else begin
            w_grp_next  = w_first;
            w_addr_next = addr_add(r_addr, ADDR_W'(1));
            if (r_addr == r_end) w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_inflight && w_empty) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_end      <= '0;
      r_grp      <= '0;
      r_mask     <= '0;
      r_inflight <= 1'b0;
      r_dgrp     <= '0;
      r_dmask    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_grp      <= w_grp_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_dgrp  <= r_grp;
        r_dmask <= w_unit_mask;
      end
      if (r_state == IDLE && start) begin
        r_mask <= conf_mask;
        r_end  <= addr_add(conf_base, conf_len);
      end
    end
  end

  always_comb begin
    w_grp_data = '0;
    for (int g = 0; g < G; g++)
      if (r_dgrp == GW'(g)) w_grp_data = bus.dbuf_rd_data[g*DDR_W +: DDR_W];
  end

  // Masked-off PEs inside an active group contribute a zero slot.
  for (genvar gi = 0; gi < 4; gi++) begin : g_unit
    assign w_push_data[gi*UW +: UW] = r_dmask[gi] ? unit_post(w_grp_data[gi*UW +: UW]) : '0;
  end

  sync_fifo #(.WIDTH(DDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign done             = (r_state == IDLE);
  assign bus.dbuf_rd_addr = r_addr;
  assign bus.dbuf_rd_en   = w_issue ? w_sel_mask : '0;
  assign bus.ddr_valid    = !w_empty;
  assign bus.ddr_data     = w_head;
  assign w_pop            = bus.ddr_valid && bus.ddr_ready;
endmodule

// File: tb/tb_dbuf2ddr.sv
// Randomised scoreboard bench for dbuf2ddr: a loop-based reference model queues expected reads and beats,
// independent monitors pop and compare them.
module tb_dbuf2ddr;
  import GLOBAL_PARAM::*;

  localparam int PE = 32;
  localparam int AD = 256;
  localparam int FD = 4;
`ifdef DBUF2DDR_RELU_EN
  localparam logic [15:0] RELU_NEG_EXP = 16'h0000;
`else
  localparam logic [15:0] RELU_NEG_EXP = 16'hFFFE;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [7:0]  conf_base = '0;
  logic [7:0]  conf_len = '0;
  logic [31:0] conf_mask = '0;

  dbuf2ddr_if #(.ADDR_W(8), .PE_NUM(PE)) bus ();

  dbuf2ddr #(.BUF_DEPTH(AD), .ADDR_W(8), .PE_NUM(PE), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .conf_base (conf_base),
    .conf_len  (conf_len),
    .conf_mask (conf_mask),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           ready_mode = 1;
  int           pat_idx = 0;
  int           start_cyc = 0;
  bit           lat_armed = 0;
  int           issued = 0;
  int           popped = 0;
  int           nbeats = 0;
  bit           hold_pending = 0;
  logic [127:0] held;
  logic [127:0] last_beat;
  logic [127:0] exp_q[$];
  logic [39:0]  rd_q[$];
  logic [31:0]  mem [PE][AD];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
    logic [31:0] r = w;
`ifdef DBUF2DDR_RELU_EN
    for (int e = 0; e < 2; e++)
      if (w[e*16 + 15]) r[e*16 +: 16] = 16'h0;
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: 1-cycle read latency, garbage on lanes that were not enabled.
  always @(posedge clk) begin
    for (int p = 0; p < PE; p++)
      bus.dbuf_rd_data[p*32 +: 32] <= bus.dbuf_rd_en[p] ? mem[p][bus.dbuf_rd_addr] : $urandom;
  end

  initial begin
    bus.ddr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.ddr_ready = 1'b0;
        1: bus.ddr_ready = 1'b1;
        2: begin
          bus.ddr_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
          pat_idx++;
        end
        default: bus.ddr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_pending = 0;
        issued = 0;
        popped = 0;
      end else begin
        if (bus.dbuf_rd_en != '0) begin
          issued++;
          if (rd_q.size() == 0) chk("unexpected_read", bus.dbuf_rd_en, 0);
          else chk("read_addr_en", {bus.dbuf_rd_addr, bus.dbuf_rd_en}, rd_q.pop_front());
          chk("fifo_occupancy", (issued - popped) <= FD, 1);
        end
        if (hold_pending) chk("stall_hold", {bus.ddr_valid, bus.ddr_data}, {1'b1, held});
        if (bus.ddr_valid && lat_armed) begin
          chk("first_valid_latency", cyc - start_cyc, 3);
          lat_armed = 0;
        end
        if (bus.ddr_valid && bus.ddr_ready) begin
          popped++;
          nbeats++;
          if (exp_q.size() == 0) chk("unexpected_beat", bus.ddr_valid, 0);
          else chk("beat_data", bus.ddr_data, exp_q.pop_front());
          chk("done_low_while_valid", done, 0);
          last_beat = bus.ddr_data;
          $display("beat %0d data=%h", nbeats, bus.ddr_data);
          hold_pending = 0;
        end else if (bus.ddr_valid) begin
          hold_pending = 1;
          held = bus.ddr_data;
        end else begin
          hold_pending = 0;
        end
      end
    end
  end

  // Queue the expected reads and beats, then pulse start; conf is scrambled afterwards.
  task automatic start_run(input logic [7:0] base, input logic [7:0] len,
                           input logic [31:0] mask, input bit meas);
    logic [127:0] beat;
    int a;
    for (int k = 0; k <= int'(len); k++) begin
      a = (int'(base) + k) % AD;
      for (int g = 0; g < PE / 4; g++) begin
        if (mask[4*g +: 4] != 4'b0) begin
          rd_q.push_back({8'(a), mask & (32'hF << (4*g))});
          beat = '0;
          for (int j = 0; j < 4; j++)
            if (mask[4*g + j]) beat[j*32 +: 32] = model_word(mem[4*g + j][a]);
          exp_q.push_back(beat);
        end
      end
    end
    conf_base = base;
    conf_len  = len;
    conf_mask = mask;
    start     = 1'b1;
    start_cyc = cyc;
    lat_armed = meas;
    tick();
    start = 1'b0;
    chk("done_cleared", done, 0);
    conf_base = 8'($urandom);
    conf_len  = 8'($urandom);
    conf_mask = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done && exp_q.size() == 0 && rd_q.size() == 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_complete"}, n < 3000, 1);
    $display("run %s finished after %0d cycles", name, n);
    exp_q.delete();
    rd_q.delete();
  endtask

  initial begin
    for (int p = 0; p < PE; p++)
      for (int a = 0; a < AD; a++)
        mem[p][a] = $urandom;

    #1 rst = 1'b0;
    #1;
    chk("reset_done", done, 1);
    chk("reset_valid", bus.ddr_valid, 0);
    chk("reset_rd_en", bus.dbuf_rd_en, 0);
    chk("reset_rd_addr", bus.dbuf_rd_addr, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    ready_mode = 1;
    start_run(8'd0, 8'd3, 32'h0000_000F, 1);
    wait_done("basic");

    start_run(8'd0, 8'd1, 32'h0F00_00F0, 0);
    wait_done("multi_group");

    // start pulse mid-run must be ignored
    ready_mode = 2;
    start_run(8'd0, 8'd15, 32'h0000_000F, 0);
    repeat (3) tick();
    conf_mask = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("backpressure");

    ready_mode = 1;
    start_run(8'd5, 8'd2, 32'h0000_0005, 0);
    wait_done("partial_mask");

    start_run(8'd9, 8'd4, 32'h0, 0);
    tick();
    chk("empty_mask_done", done, 1);
    wait_done("empty_mask");

    ready_mode = 0;
    start_run(8'd0, 8'd15, 32'h0000_00FF, 0);
    repeat (8) tick();
    chk("pre_reset_valid", bus.ddr_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_valid", bus.ddr_valid, 0);
    chk("mid_reset_done", done, 1);
    exp_q.delete();
    rd_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    ready_mode = 1;
    tick();

    start_run(8'd254, 8'd3, 32'h0000_000F, 0);
    wait_done("wrap");

    mem[0][10] = 32'h0005_FFFE;
    start_run(8'd10, 8'd0, 32'h0000_0001, 0);
    wait_done("relu");
    chk("relu_neg_elem", last_beat[15:0], RELU_NEG_EXP);
    chk("relu_pos_elem", last_beat[31:16], 16'h0005);

    ready_mode = 3;
    for (int r = 0; r < 8; r++) begin
      start_run(8'($urandom), 8'($urandom_range(0, 6)), $urandom & $urandom & $urandom, 0);
      wait_done("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dbuf2ddr.md
Name: dbuf2ddr

Overview:
- Drains PE result buffers into a single DDR write stream: the read-side counterpart of the DDR-to-dbuf loader.
- On start, sweeps a configured address range across every enabled 4-PE group and reads one row per group per address.
- Packs each group's 4 PE words into one DDR_W beat and emits it on a valid/ready stream with full backpressure.
- Sits between the PE array buffer read ports and the DDR write DMA.

Parameters:
- BUF_DEPTH, 256, words per PE buffer.
- ADDR_W, bw(BUF_DEPTH), buffer address width.
- PE_NUM, 32, PE count; must be a multiple of 4. Groups G = PE_NUM/4.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the conf_* inputs.
- done  out  1  high when idle.
- conf_base  in  ADDR_W  first buffer address.
- conf_len  in  ADDR_W  number of addresses minus 1.
- conf_mask  in  PE_NUM  PE enable; a group is active if any of its 4 bits is set.
- dbuf_rd_addr  out  ADDR_W  shared read address.
- dbuf_rd_en  out  PE_NUM  per-PE read enable.
- dbuf_rd_data  in  PE_NUM*BATCH*DATA_W  read data, 1-cycle latency after rd_en.
- ddr_data  out  DDR_W  beat; DDR_W = 4*BATCH*DATA_W. Unit j of the group occupies bits [j*BATCH*DATA_W +: BATCH*DATA_W].
- ddr_valid  out  1  beat valid.
- ddr_ready  in  1  sink ready.

Behaviour:
- Reset values: done=1, ddr_valid=0, dbuf_rd_en=0, dbuf_rd_addr=0; FIFO empty; state IDLE.
- State IDLE:
  - On start, latch conf, set addr=conf_base, grp = lowest active group, and clear done.
  - If no group is active, go to DRAIN; done reasserts 1 cycle later with no beats emitted.
  - Otherwise go to RUN.
  - start is ignored outside IDLE.
- State RUN: issue one read per cycle when credit is available.
  - Credit condition: fifo_count + inflight < FIFO_DEPTH, where inflight is a 0/1 read-latency flag.
  - On issue, dbuf_rd_en = conf_mask bits of group grp only. Masked-off PEs inside an active group are not read; their DDR slot is driven with 0.
  - Order: grp advances over active groups in ascending index. After the last active group, grp wraps to the first active group and addr increments.
  - After the issue at addr = conf_base+conf_len on the last active group, go to DRAIN.
  - Address arithmetic is mod BUF_DEPTH (wraps past BUF_DEPTH-1 to 0).
- State DRAIN: wait for inflight=0 and an empty FIFO, then set done=1 and return to IDLE.
- Data path: read data returning on the cycle after issue is pushed into the FIFO. The group select is delayed 1 cycle alongside the data to mux the 4 units.
- Output stream:
  - ddr_valid = FIFO non-empty; ddr_data = FIFO head.
  - Pop when valid && ready.
  - ddr_data holds stable while valid && !ready.
  - A push and pop in the same cycle leave the count unchanged.
- Throughput: 1 beat/cycle under continuous ready. Latency from start to first ddr_valid = 3 cycles (latch, issue, push).
- Total beats = (conf_len+1) * active_group_count.
- Reset mid-operation: the FIFO flushes, ddr_valid drops immediately (async), and done=1.

Optional Feature:
- Macro DBUF2DDR_RELU_EN.
- Defined: each DATA_W signed element is clamped to 0 if negative, on the FIFO push path, adding no latency.
- Undefined: data passes through bit-exact.

Decomposition:
- GLOBAL_PARAM package holds DDR_W, DATA_W, BATCH, bw().
- Add to GLOBAL_PARAM: a dbuf2ddr state enum typedef {IDLE, RUN, DRAIN} and a localparam GRP_W = bw(PE_NUM/4).
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; outputs count, empty, full), instantiated for the output buffer.

Test Plan:
- Basic sweep: conf_mask=32'h0000_000F, base=0, len=3, ready=1.
  - Expect 4 beats, addresses 0..3, rd_en=0xF each cycle.
  - done rises after the 4th handshake; first valid 3 cycles after start.
- Multi-group order: mask=32'h0F00_00F0, len=1.
  - Expect 4 beats in order (a0,g1), (a0,g6), (a1,g1), (a1,g6).
- Backpressure: ready toggled 1-0-0-1 with len=15, mask=0xF.
  - ddr_data stable while stalled; no beat lost or duplicated (compare to a scoreboard).
  - FIFO never exceeds 4 entries; rd_en stops while credit is exhausted.
- Partial and empty masks:
  - mask=0x5: slots 1 and 3 are zero and rd_en=0x5.
  - mask=0: done returns 1 within 2 cycles, ddr_valid never asserts.
- Wrap and reset: base=254, len=3 gives addresses 254, 255, 0, 1. Asserting rst low mid-transfer forces ddr_valid=0 and done=1 immediately; a subsequent start runs cleanly.
- RELU (macro defined): element 16'hFFFE becomes 0 and 16'h0005 stays 5. With the macro undefined, 16'hFFFE passes through unchanged.
